// File: rtl/aes192_cipher_core.sv
// AES-192 iterative encryption core: one round per clock, 12 rounds per block,
// round keys supplied externally by the key-expansion stage.
module aes192_cipher_core (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:1663] keys,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  data_out,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // FIPS-197 S-box, byte x lives at bits [8x +: 8] (bit 8x is its MSB)
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state;
  logic [3:0]   rnd;
  logic [0:127] st;
  logic [0:127] sr;
  logic [0:127] mc;
  logic [0:127] rk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] mix_column(input logic [0:31] col);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = col[0:7];
    a1 = col[8:15];
    a2 = col[16:23];
    a3 = col[24:31];
    t  = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Round datapath: SubBytes+ShiftRows, MixColumns, and round-key select by rnd
  always_comb begin
    sr = '0;
    mc = '0;
    rk = keys[0 +: 128];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(4*c+r) +: 8] = sbox(st[8*(4*((c+r)%4)+r) +: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end
    for (int r = 1; r < 13; r++) begin
      if (rnd == 4'(r)) rk = keys[r*128 +: 128];
    end
  end

  // Control FSM with registered state, round counter, result and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      st        <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= data_in ^ keys[0 +: 128];
            rnd   <= 4'd1;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd == 4'd12) begin
            data_out  <= sr ^ rk;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            st  <= mc ^ rk;
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes192_cipher_core.sv
// Self-checking bench for aes192_cipher_core using a ciphertext scoreboard.
module tb_aes192_cipher_core;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:1663] keys;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  data_in;
  logic          out_valid;
  logic          out_ready;
  logic [0:127]  data_out;
  logic          busy;

  aes192_cipher_core dut (
    .clk(clk), .rst(rst), .keys(keys),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy)
  );

  localparam logic [191:0] KEY_FIPS = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] KEY_SP   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  int           cyc = 0;
  int           vec_count = 0;
  int           miss_count = 0;
  int           accept_count = 0;
  int           valid_rises = 0;
  logic         prev_valid = 1'b0;
  logic [127:0] cur_exp;
  logic [127:0] exp_q[$];
  int           acc_q[$];

  always #5 clk = ~clk;

  // Edge counter used for latency and issue-interval measurements
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box derived from the GF(2^8) inverse and affine map, not from a table
  function automatic logic [7:0] sboxModel(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1663:0] expandKey(input logic [191:0] k);
    logic [31:0]   w[52];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1663:0] ks;
    rcon = 8'h01;
    ks = '0;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxModel(t[31:24]) ^ rcon, sboxModel(t[23:16]), sboxModel(t[15:8]), sboxModel(t[7:0])};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int i = 0; i < 52; i++) ks[1663-32*i -: 32] = w[i];
    return ks;
  endfunction

  // Monitor: push expectations on acceptance, check latency and ciphertext on output
  always @(negedge clk) begin
    int a;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc + 1);
        accept_count++;
      end
      if (out_valid && !prev_valid) begin
        valid_rises++;
        if (acc_q.size() == 0) checkOutput("spurious_valid", 1, 0);
        else begin
          a = acc_q.pop_front();
          checkOutput("latency", 128'(cyc - a), 128'd12);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("unexpected_output", data_out, 0);
        else checkOutput("ciphertext", data_out, exp_q.pop_front());
      end
    end
    prev_valid = out_valid;
  end

  task automatic applyStimulus(input logic [127:0] blk, input logic [127:0] expct,
                               input bit hold_valid, output int acc_edge);
    int start;
    start = accept_count;
    in_valid = 1'b1;
    data_in = blk;
    cur_exp = expct;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (accept_count != start) break;
    end
    if (accept_count == start) checkOutput("accept_timeout", 0, 1);
    acc_edge = cyc;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 128'(exp_q.size()), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_data_out"}, data_out, 0);
  endtask

  initial begin
    logic [127:0] pt[4];
    logic [127:0] ct[4];
    int           e[4];
    int           dummy;
    int           start;
    int           rises;

    pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a; ct[0] = 128'hbd334f1d6e45f25ff712a214571fa5cc;
    pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; ct[1] = 128'h974104846d0ad3ad7734ecb3ecee4eef;
    pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; ct[2] = 128'hef7afd2270e2e60adce0ba2face6444e;
    pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; ct[3] = 128'h9a4b41ba738d6c72fb16691603c18e0e;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    data_in = '0;
    cur_exp = '0;
    keys = expandKey(KEY_FIPS);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetOutputs("reset");

    $display("[TB] FIPS-197 C.2 vector");
    applyStimulus(128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, dummy);
    waitDrain();

    $display("[TB] SP800-38A F.1.3 block 1");
    keys = expandKey(KEY_SP);
    applyStimulus(pt[0], ct[0], 1'b0, dummy);
    waitDrain();

    $display("[TB] Backpressure");
    out_ready = 1'b0;
    applyStimulus(pt[1], ct[1], 1'b0, dummy);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    checkOutput("bp_out_valid", out_valid, 1);
    in_valid = 1'b1;
    data_in = pt[2];
    cur_exp = ct[2];
    start = accept_count;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold", data_out, ct[1]);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    checkOutput("bp_no_capture", 128'(accept_count - start), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_idle", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("bp_pending_accept", 128'(accept_count - start), 1);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] Back-to-back");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pt[i], ct[i], (i < 3), e[i]);
      if (i > 0) checkOutput("b2b_interval", 128'(e[i] - e[i-1]), 128'd14);
    end
    waitDrain();

    $display("[TB] Reset mid-operation");
    applyStimulus(pt[0], ct[0], 1'b0, dummy);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    rises = valid_rises;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetOutputs("midrst");
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst_no_valid", 128'(valid_rises - rises), 0);
    applyStimulus(pt[1], ct[1], 1'b0, dummy);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
